// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL lock sequencer slice.
//   state_e        : sequencer states (RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT)
//   ST_*           : the same encodings as plain logic constants for the FSM
//   RETRY_W/LOSS_W : widths of the retry and lock-loss counters
//   cntWidth()     : width of the shared cycle counter for a given set of
//                    cycle parameters
// ---------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_RESET_PLL = RESET_PLL;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = WAIT_LOCK;
    localparam logic [STATE_W-1:0] ST_STABILIZE = STABILIZE;
    localparam logic [STATE_W-1:0] ST_RUN       = RUN;
    localparam logic [STATE_W-1:0] ST_FAULT     = FAULT;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // The shared counter only has to reach the largest terminal count minus
    // one; the extra bit keeps the compare values comfortably in range.
    function automatic int cntWidth(input int holdCycles,
                                    input int stableCycles,
                                    input int timeoutCycles);
        int m;
        m = holdCycles;
        if (stableCycles > m) begin
            m = stableCycles;
        end
        if (timeoutCycles > m) begin
            m = timeoutCycles;
        end
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level into the i_clk domain.
// Both flops clear to 0 on the synchronous, active-high reset.
// Ports:
//   i_clk   : destination clock
//   i_rst   : synchronous active-high reset
//   i_d     : asynchronous input level
//   o_q     : synchronized level, two cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff
    import pll_seq_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; the second gives it a full cycle to
    // settle before anything downstream looks at the level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
// Reset and lock controller for the system PLL, clocked by the PLL reference
// clock. Pulses the PLL reset, waits for a stable lock, then releases the
// downstream system reset. Re-sequences on lock loss or software request and
// latches a fault after repeated lock timeouts.
//
// Build option: define PLL_LOCK_STATS_EN to implement the lock-loss counter;
// without it o_lock_loss_cnt is tied to zero.
//
// Ports:
//   i_refclk        : reference clock, the only clock
//   i_rst           : synchronous active-high reset
//   i_pll_locked    : PLL lock flag, asynchronous to i_refclk
//   i_relock_req    : single-cycle pulse, restart the sequence from any state
//   o_pll_rst       : reset to the PLL (high in RESET_PLL and FAULT)
//   o_sys_rst       : downstream system reset, low only in RUN
//   o_ready         : high only in RUN
//   o_fault         : high only in FAULT
//   o_retry_cnt     : failed lock attempts since the last RUN
//   o_lock_loss_cnt : saturating count of lock losses seen in RUN
// ---------------------------------------------------------------------------
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 4
)(
    input  logic       i_refclk,
    input  logic       i_rst,
    input  logic       i_pll_locked,
    input  logic       i_relock_req,
    output logic       o_pll_rst,
    output logic       o_sys_rst,
    output logic       o_ready,
    output logic       o_fault,
    output logic [3:0] o_retry_cnt,
    output logic [7:0] o_lock_loss_cnt
);

    localparam int CNT_W = cntWidth(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES,
                                    LOCK_TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    logic                 w_lockedS;
    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_nextState;
    logic [CNT_W-1:0]     r_cnt;
    logic [RETRY_W-1:0]   r_retryCnt;
    logic [RETRY_W-1:0]   w_nextRetry;
    logic                 w_restart;
    logic                 r_pllRst;
    logic                 r_sysRst;
    logic                 r_ready;
    logic                 r_fault;

    sync_2ff u_lockSync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_lockedS)
    );

    // Next-state and retry bookkeeping. A relock request overrides every
    // other exit condition and also forces the cycle counter to restart even
    // when we are already in RESET_PLL, so the PLL gets a full-length pulse.
    always_comb begin
        w_nextState = r_state;
        w_nextRetry = r_retryCnt;
        w_restart   = 1'b0;
        if (i_relock_req) begin
            w_nextState = ST_RESET_PLL;
            w_restart   = 1'b1;
            if (r_state == ST_FAULT) begin
                w_nextRetry = '0;
            end
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_nextState = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lockedS) begin
                        w_nextState = ST_STABILIZE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_nextRetry = r_retryCnt + RETRY_W'(1);
                        if ((r_retryCnt + RETRY_W'(1)) == RETRY_LIMIT) begin
                            w_nextState = ST_FAULT;
                        end else begin
                            w_nextState = ST_RESET_PLL;
                        end
                    end
                end
                ST_STABILIZE: begin
                    if (!w_lockedS) begin
                        w_nextState = ST_WAIT_LOCK;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_nextState = ST_RUN;
                        w_nextRetry = '0;
                    end
                end
                ST_RUN: begin
                    if (!w_lockedS) begin
                        w_nextState = ST_RESET_PLL;
                    end
                end
                ST_FAULT: begin
                    w_nextState = ST_FAULT;
                end
                default: begin
                    w_nextState = ST_RESET_PLL;
                end
            endcase
        end
    end

    // State, retry count and the shared cycle counter. The counter measures
    // time spent in the current state, so it clears on any state change.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state    <= ST_RESET_PLL;
            r_retryCnt <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_nextState;
            r_retryCnt <= w_nextRetry;
            if (w_restart || (w_nextState != r_state)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Output flops are loaded from the next-state decode so that they always
    // match the state register without an extra cycle of lag.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_pllRst <= 1'b1;
            r_sysRst <= 1'b1;
            r_ready  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_pllRst <= (w_nextState == ST_RESET_PLL) || (w_nextState == ST_FAULT);
            r_sysRst <= (w_nextState != ST_RUN);
            r_ready  <= (w_nextState == ST_RUN);
            r_fault  <= (w_nextState == ST_FAULT);
        end
    end

`ifdef PLL_LOCK_STATS_EN
    logic [LOSS_W-1:0] r_lockLossCnt;

    // Lock losses are counted even when a relock request arrives in the same
    // cycle; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_lockLossCnt <= '0;
        end else if ((r_state == ST_RUN) && !w_lockedS && (r_lockLossCnt != '1)) begin
            r_lockLossCnt <= r_lockLossCnt + LOSS_W'(1);
        end
    end

    assign o_lock_loss_cnt = r_lockLossCnt;
`else
    assign o_lock_loss_cnt = {LOSS_W{1'b0}};
`endif

    assign o_pll_rst   = r_pllRst;
    assign o_sys_rst   = r_sysRst;
    assign o_ready     = r_ready;
    assign o_fault     = r_fault;
    assign o_retry_cnt = r_retryCnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
// Directed scenarios with hand-computed expectations followed by randomized
// lock/relock/reset traffic, all checked every cycle against a phase/age
// model of the sequencer kept in this bench.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int HOLD    = 4;
    localparam int STABLE  = 8;
    localparam int TIMEOUT = 32;
    localparam int RETRIES = 2;

    logic       clk;
    logic       rst;
    logic       pllLocked;
    logic       relockReq;
    logic       pllRst;
    logic       sysRst;
    logic       ready;
    logic       fault;
    logic [3:0] retryCnt;
    logic [7:0] lockLossCnt;

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (HOLD),
        .LOCK_STABLE_CYCLES  (STABLE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES         (RETRIES)
    ) dut (
        .i_refclk        (clk),
        .i_rst           (rst),
        .i_pll_locked    (pllLocked),
        .i_relock_req    (relockReq),
        .o_pll_rst       (pllRst),
        .o_sys_rst       (sysRst),
        .o_ready         (ready),
        .o_fault         (fault),
        .o_retry_cnt     (retryCnt),
        .o_lock_loss_cnt (lockLossCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: which phase we are in, how many cycles have been
    // spent there, and the last two sampled lock values.
    typedef enum {PH_HOLD, PH_WAIT, PH_STAB, PH_RUN, PH_FAULT} phase_t;

    phase_t mPhase = PH_HOLD;
    int     mAge   = 0;
    int     mRetry = 0;
    int     mLoss  = 0;
    bit     mValid = 1'b0;
    bit     lockHist[$];

    always @(posedge clk) begin
        bit     ls;
        bit     restart;
        phase_t nxt;
        if (rst) begin
            mPhase   = PH_HOLD;
            mAge     = 0;
            mRetry   = 0;
            mLoss    = 0;
            lockHist = '{1'b0, 1'b0};
            mValid   = 1'b1;
        end else if (mValid) begin
            ls      = lockHist[0];
            restart = 1'b0;
            nxt     = mPhase;
            mAge    = mAge + 1;
`ifdef PLL_LOCK_STATS_EN
            if (mPhase == PH_RUN && !ls && mLoss < 255) mLoss = mLoss + 1;
`endif
            if (relockReq) begin
                if (mPhase == PH_FAULT) mRetry = 0;
                nxt     = PH_HOLD;
                restart = 1'b1;
            end else begin
                case (mPhase)
                    PH_HOLD: if (mAge == HOLD) nxt = PH_WAIT;
                    PH_WAIT: begin
                        if (ls) nxt = PH_STAB;
                        else if (mAge == TIMEOUT) begin
                            mRetry = mRetry + 1;
                            nxt = (mRetry == RETRIES) ? PH_FAULT : PH_HOLD;
                        end
                    end
                    PH_STAB: begin
                        if (!ls) nxt = PH_WAIT;
                        else if (mAge == STABLE) begin
                            nxt    = PH_RUN;
                            mRetry = 0;
                        end
                    end
                    PH_RUN:  if (!ls) nxt = PH_HOLD;
                    default: nxt = mPhase;
                endcase
            end
            if (restart || nxt != mPhase) mAge = 0;
            mPhase = nxt;
            lockHist.push_back(pllLocked);
            void'(lockHist.pop_front());
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("pll_rst", {7'd0, pllRst}, {7'd0, (mPhase == PH_HOLD || mPhase == PH_FAULT)});
            checkOutput("sys_rst", {7'd0, sysRst}, {7'd0, (mPhase != PH_RUN)});
            checkOutput("ready", {7'd0, ready}, {7'd0, (mPhase == PH_RUN)});
            checkOutput("fault", {7'd0, fault}, {7'd0, (mPhase == PH_FAULT)});
            checkOutput("retry_cnt", {4'd0, retryCnt}, 8'(mRetry));
            checkOutput("lock_loss_cnt", lockLossCnt, 8'(mLoss));
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lockVal, input logic relockVal, input logic rstVal, input int cycles);
        pllLocked = lockVal;
        relockReq = relockVal;
        rst       = rstVal;
        waitCycles(cycles);
    endtask

    task automatic waitForPhase(input phase_t ph, input int budget);
        int n;
        n = 0;
        while (mPhase != ph && n < budget) begin
            waitCycles(1);
            n = n + 1;
        end
        checks = checks + 1;
        if (mPhase != ph) begin
            errors = errors + 1;
            $display("[TB] FAIL phase_wait: got phase %0d expected %0d within %0d cycles", mPhase, ph, budget);
        end
    endtask

    int expLoss;
    bit lockedVal;
    int holdLeft;

    initial begin
        pllLocked = 1'b0;
        relockReq = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // Cycle 0 of nominal bring-up.
        waitCycles(3);
        checkOutput("nom_pll_rst_c3", {7'd0, pllRst}, 8'd1);
        waitCycles(1);
        checkOutput("nom_pll_rst_c4", {7'd0, pllRst}, 8'd0);
        waitCycles(2);
        pllLocked = 1'b1;
        waitCycles(10);
        checkOutput("nom_ready_c16", {7'd0, ready}, 8'd0);
        waitCycles(1);
        checkOutput("nom_ready_c17", {7'd0, ready}, 8'd1);
        checkOutput("nom_sys_rst_c17", {7'd0, sysRst}, 8'd0);

        // Lock loss in RUN.
        waitCycles(5);
        pllLocked = 1'b0;
        waitCycles(2);
        checkOutput("loss_sys_rst_t2", {7'd0, sysRst}, 8'd0);
        waitCycles(1);
        checkOutput("loss_sys_rst_t3", {7'd0, sysRst}, 8'd1);
`ifdef PLL_LOCK_STATS_EN
        expLoss = 1;
`else
        expLoss = 0;
`endif
        checkOutput("loss_count", lockLossCnt, 8'(expLoss));
        waitCycles(6);
        pllLocked = 1'b1;

        // Glitch after five stable cycles in STABILIZE.
        waitForPhase(PH_STAB, 100);
        waitCycles(3);
        pllLocked = 1'b0;
        waitCycles(1);
        pllLocked = 1'b1;
        waitCycles(2);
        checkOutput("glitch_sys_rst", {7'd0, sysRst}, 8'd1);
        checkOutput("glitch_retry", {4'd0, retryCnt}, 8'd0);
        waitCycles(8);
        checkOutput("glitch_ready_early", {7'd0, ready}, 8'd0);
        waitCycles(1);
        checkOutput("glitch_ready", {7'd0, ready}, 8'd1);

        // Reset in the middle of STABILIZE.
        waitCycles(3);
        pllLocked = 1'b0;
        waitCycles(8);
        pllLocked = 1'b1;
        waitForPhase(PH_STAB, 100);
        waitCycles(2);
        rst       = 1'b1;
        pllLocked = 1'b0;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("rst_pll_rst", {7'd0, pllRst}, 8'd1);
        checkOutput("rst_sys_rst", {7'd0, sysRst}, 8'd1);
        checkOutput("rst_ready", {7'd0, ready}, 8'd0);
        checkOutput("rst_fault", {7'd0, fault}, 8'd0);
        checkOutput("rst_loss", lockLossCnt, 8'd0);

        // Timeouts to fault, counted from this cycle 0.
        waitCycles(35);
        checkOutput("to_retry_c35", {4'd0, retryCnt}, 8'd0);
        waitCycles(1);
        checkOutput("to_retry_c36", {4'd0, retryCnt}, 8'd1);
        checkOutput("to_pll_rst_c36", {7'd0, pllRst}, 8'd1);
        waitCycles(4);
        checkOutput("to_pll_rst_c40", {7'd0, pllRst}, 8'd0);
        waitCycles(31);
        checkOutput("to_fault_c71", {7'd0, fault}, 8'd0);
        waitCycles(1);
        checkOutput("to_fault_c72", {7'd0, fault}, 8'd1);
        checkOutput("to_retry_c72", {4'd0, retryCnt}, 8'd2);
        waitCycles(200);
        checkOutput("fault_hold", {7'd0, fault}, 8'd1);
        checkOutput("fault_pll_rst", {7'd0, pllRst}, 8'd1);
        checkOutput("fault_sys_rst", {7'd0, sysRst}, 8'd1);

        // Fault recovery via relock.
        pllLocked = 1'b1;
        waitCycles(5);
        relockReq = 1'b1;
        waitCycles(1);
        relockReq = 1'b0;
        checkOutput("rec_retry", {4'd0, retryCnt}, 8'd0);
        checkOutput("rec_fault", {7'd0, fault}, 8'd0);
        checkOutput("rec_pll_rst", {7'd0, pllRst}, 8'd1);
        waitCycles(13);
        checkOutput("rec_ready", {7'd0, ready}, 8'd1);

        // Repeated lock losses to drive the loss counter into saturation.
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4);
            applyStimulus(1'b1, 1'b0, 1'b0, 20);
        end
`ifdef PLL_LOCK_STATS_EN
        expLoss = 255;
`else
        expLoss = 0;
`endif
        checkOutput("loss_saturate", lockLossCnt, 8'(expLoss));

        // Randomized traffic: lock held in random-length runs, occasional
        // relock pulses and resets.
        lockedVal = 1'b1;
        holdLeft  = 0;
        for (int i = 0; i < 3000; i++) begin
            if (holdLeft == 0) begin
                lockedVal = ~lockedVal;
                holdLeft  = lockedVal ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 90));
            end
            holdLeft = holdLeft - 1;
            applyStimulus(lockedVal, ($urandom_range(0, 199) == 0), ($urandom_range(0, 399) == 0), 1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
